// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light timer and controller: one-hot light
// encodings, timer FSM states and the legal phase successor function.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b001;
  localparam logic [2:0] LIGHT_GREEN  = 3'b010;
  localparam logic [2:0] LIGHT_YELLOW = 3'b100;

  typedef enum logic [1:0] {
    TIMING    = 2'd0,
    WAIT_STEP = 2'd1,
    FAULT     = 2'd2
  } tmr_state_e;

  // Only red->green->yellow->red is legal; anything else yields 000 (never matches).
  function automatic logic [2:0] light_next(input logic [2:0] cur);
    logic [2:0] nxt;
    case (cur)
      LIGHT_RED:    nxt = LIGHT_GREEN;
      LIGHT_GREEN:  nxt = LIGHT_YELLOW;
      LIGHT_YELLOW: nxt = LIGHT_RED;
      default:      nxt = 3'b000;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/traffic_phase_timer_if.sv
// Signal bundle between the phase timer (slave) and the controller side (master).
// The hold signal exists only when TRAFFIC_TIMER_HOLD_EN is defined.
interface traffic_phase_timer_if #(
  parameter int CNT_W = 8
) ();
  logic [2:0]       light_state;
  logic             ped_req;
`ifdef TRAFFIC_TIMER_HOLD_EN
  logic             hold;
`endif
  logic             advance;
  logic             ped_ack;
  logic             ped_walk;
  logic [CNT_W-1:0] remaining;
  logic             fault;

`ifdef TRAFFIC_TIMER_HOLD_EN
  modport master (output light_state, ped_req, hold,
                  input  advance, ped_ack, ped_walk, remaining, fault);
  modport slave  (input  light_state, ped_req, hold,
                  output advance, ped_ack, ped_walk, remaining, fault);
`else
  modport master (output light_state, ped_req,
                  input  advance, ped_ack, ped_walk, remaining, fault);
  modport slave  (input  light_state, ped_req,
                  output advance, ped_ack, ped_walk, remaining, fault);
`endif
endinterface

// File: rtl/dwell_counter.sv
// Loadable saturating down-counter: load wins over decrement, decrement stops at zero.
module dwell_counter #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load, saturating decrement, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == {CNT_W{1'b0}});
endmodule

// File: rtl/traffic_phase_timer.sv
// Phase dwell timer ahead of the traffic light controller: strobes advance when a
// phase expires, extends red for pedestrians, latches a sticky fault on bad input.
// Optional TRAFFIC_TIMER_HOLD_EN adds a hold input that freezes the countdown.
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int RED_CYCLES       = 8,
  parameter int GREEN_CYCLES     = 12,
  parameter int YELLOW_CYCLES    = 3,
  parameter int PED_EXTRA_CYCLES = 6,
  parameter int CNT_W            = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_phase_timer_if.slave bus
);
  localparam logic [CNT_W-1:0] RED_LD     = CNT_W'(RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] RED_PED_LD = CNT_W'(RED_CYCLES + PED_EXTRA_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_LD   = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD  = CNT_W'(YELLOW_CYCLES - 1);

  tmr_state_e       state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic             advance_q, advance_d;
  logic             ped_ack_q, ped_ack_d;
  logic             ped_walk_q, ped_walk_d;
  logic             ped_pending_q, ped_pending_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_s, load_val_s;
  logic             load_s, dec_s, zero_s, hold_s, entry_s;
  logic             change_s, onehot_s, legal_s;

`ifdef TRAFFIC_TIMER_HOLD_EN
  assign hold_s = bus.hold;
`else
  assign hold_s = 1'b0;
`endif

  assign change_s = (bus.light_state != prev_q);
  assign onehot_s = $onehot(bus.light_state);
  assign legal_s  = (light_next(prev_q) == bus.light_state);
  assign load_s   = entry_s;

  // Next state; a legal change is only accepted once the dwell has run out
  always_comb begin
    state_d = state_q;
    entry_s = 1'b0;
    case (state_q)
      TIMING, WAIT_STEP: begin
        if (!onehot_s) begin
          state_d = FAULT;
        end else if (change_s) begin
          if (!legal_s || ((state_q == TIMING) && !zero_s)) begin
            state_d = FAULT;
          end else begin
            state_d = TIMING;
            entry_s = 1'b1;
          end
        end else if ((state_q == TIMING) && zero_s && !hold_s) begin
          state_d = WAIT_STEP;
        end else begin
          state_d = state_q;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

  // Output and datapath decode
  always_comb begin
    prev_d        = entry_s ? bus.light_state : prev_q;
    advance_d     = (state_q == TIMING) && (state_d == WAIT_STEP);
    fault_d       = (state_d == FAULT);
    ped_ack_d     = 1'b0;
    ped_pending_d = ped_pending_q;
    ped_walk_d    = ped_walk_q;
    dec_s         = (state_q == TIMING) && (state_d == TIMING) && !entry_s && !hold_s;
    case (bus.light_state)
      LIGHT_RED:    load_val_s = ped_pending_q ? RED_PED_LD : RED_LD;
      LIGHT_GREEN:  load_val_s = GREEN_LD;
      LIGHT_YELLOW: load_val_s = YELLOW_LD;
      default:      load_val_s = {CNT_W{1'b0}};
    endcase
    if (state_d == FAULT) begin
      ped_walk_d = 1'b0;
    end else if (entry_s && (bus.light_state == LIGHT_RED)) begin
      ped_walk_d    = ped_pending_q;
      ped_pending_d = 1'b0;
    end else if (entry_s && (bus.light_state == LIGHT_GREEN)) begin
      ped_walk_d = 1'b0;
    end else begin
      ped_walk_d = ped_walk_q;
    end
    // Uses the pending value from before this edge, so a press on red entry waits a cycle
    if ((state_d != FAULT) && bus.ped_req && !ped_pending_q) begin
      ped_pending_d = 1'b1;
      ped_ack_d     = 1'b1;
    end else begin
      ped_ack_d = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TIMING;
      prev_q  <= LIGHT_RED;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
    end
  end

  // Registered outputs and pedestrian latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      advance_q     <= 1'b0;
      ped_ack_q     <= 1'b0;
      ped_walk_q    <= 1'b0;
      ped_pending_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      advance_q     <= advance_d;
      ped_ack_q     <= ped_ack_d;
      ped_walk_q    <= ped_walk_d;
      ped_pending_q <= ped_pending_d;
      fault_q       <= fault_d;
    end
  end

  dwell_counter #(
    .CNT_W   (CNT_W),
    .RST_VAL (RED_LD)
  ) u_dwell_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .dec_i      (dec_s),
    .cnt_o      (cnt_s),
    .zero_o     (zero_s)
  );

  assign bus.advance   = advance_q;
  assign bus.ped_ack   = ped_ack_q;
  assign bus.ped_walk  = ped_walk_q;
  assign bus.remaining = cnt_s;
  assign bus.fault     = fault_q;
endmodule
